multi_debouncer: RTL and testbench

Parametrised bank of mechanical button debouncers for the hardware examples. Each of `CHANNELS` active-low raw button inputs is synchronised and debounced independently. Each channel produces a debounced level, one-cycle press and release pulses, and optional hold-to-repeat pulses. It sits between board pins and counter or UI logic, and replaces per-button debouncer instances.

---
 rtl/multi_debouncer.sv | 121 ++++++++++++
 tb/tb_multi_debouncer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: bank of independent active-low button debouncers.
// Each channel has a 2-flop synchroniser, a debounce counter that must see
// 2^CNTR_WIDTH consecutive disagreeing samples before the level flips,
// one-cycle press/release pulses and an optional hold-to-repeat pulse.
// Optional feature macro: MULTI_DEBOUNCER_REPEAT_EN (defined = repeat logic
// built; undefined = rpt tied low and the repeat parameters are ignored).
module multi_debouncer #(
    parameter int CHANNELS      = 4,
    parameter int CNTR_WIDTH    = 20,
    parameter int REP_WIDTH     = 24,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_n,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] rpt
);

    // Reject parameter sets the counters cannot represent.
    if (CHANNELS < 1 || CNTR_WIDTH < 1 || REP_WIDTH < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        longint'(REPEAT_DELAY) > (longint'(1) << REP_WIDTH) ||
        longint'(REPEAT_PERIOD) > (longint'(1) << REP_WIDTH)) begin : g_bad_params
        $error("multi_debouncer: illegal parameter combination");
    end

    logic [CHANNELS-1:0] r_sync0;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] w_b;

    // Two-flop synchroniser; reset value corresponds to a released button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= {CHANNELS{1'b1}};
            r_sync1 <= {CHANNELS{1'b1}};
        end else begin
            r_sync0 <= btn_n;
            r_sync1 <= r_sync0;
        end
    end

    assign w_b = ~r_sync1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNTR_WIDTH-1:0] r_cnt;
        logic                  r_state;
        logic                  r_pressed;
        logic                  r_released;
        logic                  w_cnt_full;
        logic                  w_press_ev;
        logic                  w_rel_ev;

        assign w_cnt_full = &r_cnt;
        assign w_press_ev = w_cnt_full & w_b[g] & ~r_state;
        assign w_rel_ev   = w_cnt_full & ~w_b[g] & r_state;

        // Debounce: count disagreement, accept the new level once the
        // counter is already saturated; any agreement restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt      <= '0;
                r_state    <= 1'b0;
                r_pressed  <= 1'b0;
                r_released <= 1'b0;
            end else begin
                r_pressed  <= w_press_ev;
                r_released <= w_rel_ev;
                if (w_b[g] == r_state) begin
                    r_cnt <= '0;
                end else if (w_cnt_full) begin
                    r_state <= w_b[g];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNTR_WIDTH'(1);
                end
            end
        end

        assign state[g]    = r_state;
        assign pressed[g]  = r_pressed;
        assign released[g] = r_released;

`ifdef MULTI_DEBOUNCER_REPEAT_EN
        localparam logic [REP_WIDTH-1:0] DLY_LD = REP_WIDTH'(REPEAT_DELAY - 1);
        localparam logic [REP_WIDTH-1:0] PER_LD = REP_WIDTH'(REPEAT_PERIOD - 1);

        logic [REP_WIDTH-1:0] r_rcnt;
        logic                 r_rpt;

        // Repeat timer: loads on press, counts down while held, fires and
        // reloads at zero. A release on the same edge suppresses the pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rcnt <= '0;
                r_rpt  <= 1'b0;
            end else begin
                r_rpt <= 1'b0;
                if (w_rel_ev || (!r_state && !w_press_ev)) begin
                    r_rcnt <= '0;
                end else if (w_press_ev) begin
                    r_rcnt <= DLY_LD;
                end else if (r_rcnt == '0) begin
                    r_rpt  <= 1'b1;
                    r_rcnt <= PER_LD;
                end else begin
                    r_rcnt <= r_rcnt - REP_WIDTH'(1);
                end
            end
        end

        assign rpt[g] = r_rpt;
`else
        assign rpt[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer (CHANNELS=2, CNTR_WIDTH=3,
// REPEAT_DELAY=20, REPEAT_PERIOD=5). Repeat expectations follow the
// MULTI_DEBOUNCER_REPEAT_EN build setting.
module tb_multi_debouncer;
    localparam int CH  = 2;
    localparam int CW  = 3;
    localparam int RW  = 8;
    localparam int DLY = 20;
    localparam int PER = 5;
    localparam int THR = 1 << CW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] btn_n = 2'b11;
    logic [1:0] state, pressed, released, rpt;

    always #5 clk = ~clk;

    multi_debouncer #(
        .CHANNELS(CH), .CNTR_WIDTH(CW), .REP_WIDTH(RW),
        .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .state(state), .pressed(pressed), .released(released), .rpt(rpt)
    );

    int n_vec = 0;
    int n_err = 0;
    int t = 0;

    // Reference model: per-channel disagreement run length, last press time.
    logic [1:0] m_s0 = 2'b11, m_s1 = 2'b11, m_st = 2'b00;
    logic [1:0] e_pr = 2'b00, e_rl = 2'b00, e_rp = 2'b00;
    int         m_run [2];
    int         m_pt  [2];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d actual=%b required=%b", name, t, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s0 = 2'b11; m_s1 = 2'b11; m_st = 2'b00;
        e_pr = 2'b00; e_rl = 2'b00; e_rp = 2'b00;
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0;
            m_pt[c]  = 0;
        end
    endtask

    // The level flips on the THR-th consecutive edge that sees the
    // synchronised input differ from it; repeats come DLY edges after the
    // press edge and every PER edges thereafter while held.
    task automatic model_edge();
        logic [1:0] b;
        if (rst) begin
            model_reset();
            return;
        end
        b = ~m_s1;
        m_s1 = m_s0;
        m_s0 = btn_n;
        e_pr = 2'b00; e_rl = 2'b00; e_rp = 2'b00;
        for (int c = 0; c < CH; c++) begin
            if (b[c] != m_st[c]) begin
                m_run[c]++;
                if (m_run[c] == THR) begin
                    m_st[c]  = b[c];
                    m_run[c] = 0;
                    if (b[c]) begin
                        e_pr[c] = 1'b1;
                        m_pt[c] = t;
                    end else begin
                        e_rl[c] = 1'b1;
                    end
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef MULTI_DEBOUNCER_REPEAT_EN
            if (m_st[c] && !e_pr[c] && (t - m_pt[c]) >= DLY && ((t - m_pt[c] - DLY) % PER) == 0)
                e_rp[c] = 1'b1;
`endif
        end
    endtask

    task automatic step(input logic [1:0] bn, input logic r);
        @(negedge clk);
        btn_n = bn;
        rst   = r;
        @(posedge clk);
        model_edge();
        t++;
        #1;
        check("model_state", state, m_st);
        check("model_pressed", pressed, e_pr);
        check("model_released", released, e_rl);
        check("model_rpt", rpt, e_rp);
    endtask

    typedef struct {
        logic [1:0] bn;
        logic [1:0] st;
        logic [1:0] pr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int         cnt, cnt_bad, p_edge, guard;
        int         rpt_off[$];
        logic [1:0] lv [2];
        int         left [2];

        model_reset();
        #1;
        check("reset_state", state, 2'b00);
        check("reset_pressed", pressed, 2'b00);
        check("reset_rpt", rpt, 2'b00);
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);

        // Clean press: btn_n=2'b10 from edge 0; state/pressed rise after edge 9.
        for (int k = 0; k < 12; k++) begin
            tbl[k].bn = 2'b10;
            tbl[k].st = (k >= 9) ? 2'b01 : 2'b00;
            tbl[k].pr = (k == 9) ? 2'b01 : 2'b00;
        end
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].bn, 1'b0);
            check("tbl_state", state, tbl[k].st);
            check("tbl_pressed", pressed, tbl[k].pr);
        end

        // Release: one-cycle pulse 9 edges after first high sample.
        for (int k = 0; k < 12; k++) begin
            step(2'b11, 1'b0);
            check("release_pulse", released, (k == 9) ? 2'b01 : 2'b00);
            check("release_state", state, (k >= 9) ? 2'b00 : 2'b01);
        end

        // Bounce: 7 low / 1 high never reaches state.
        cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 7; k++) begin
                step(2'b10, 1'b0);
                if (pressed[0]) cnt++;
            end
            step(2'b11, 1'b0);
            if (pressed[0]) cnt++;
        end
        check_int("bounce_no_press", cnt, 0);
        check("bounce_state", state, 2'b00);

        // Sustained hold gives exactly one press.
        cnt = 0;
        p_edge = 0;
        for (int k = 0; k < 12; k++) begin
            step(2'b10, 1'b0);
            if (pressed[0]) begin
                cnt++;
                p_edge = t - 1;
            end
        end
        check_int("hold_single_press", cnt, 1);

        // Hold for repeats; record offsets from the press edge.
        for (int k = 0; k < 30; k++) begin
            step(2'b10, 1'b0);
            if (rpt[0]) rpt_off.push_back(t - 1 - p_edge);
        end
`ifdef MULTI_DEBOUNCER_REPEAT_EN
        check_int("rpt_count_ge3", (rpt_off.size() >= 3) ? 1 : 0, 1);
        if (rpt_off.size() >= 3) begin
            check_int("rpt_first", rpt_off[0], 20);
            check_int("rpt_second", rpt_off[1], 25);
            check_int("rpt_third", rpt_off[2], 30);
        end
`else
        check_int("rpt_absent", rpt_off.size(), 0);
`endif

        // Release timed so that the release edge lands on a repeat expiry.
        guard = 0;
        while (((t + 9 - p_edge - DLY) % PER) != 0 && guard < 10) begin
            step(2'b10, 1'b0);
            guard++;
        end
        for (int k = 0; k < 12; k++) begin
            step(2'b11, 1'b0);
            check("coincide_release", released, (k == 9) ? 2'b01 : 2'b00);
            if (k == 9) check("coincide_no_rpt", rpt, 2'b00);
        end

        // Async reset mid-hold.
        for (int k = 0; k < 12; k++) step(2'b10, 1'b0);
        check("held_before_reset", state, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", state, 2'b00);
        check("async_rst_pressed", pressed, 2'b00);
        check("async_rst_released", released, 2'b00);
        check("async_rst_rpt", rpt, 2'b00);
        model_reset();
        for (int k = 0; k < 3; k++) step(2'b10, 1'b1);
        // First edge after deassert samples the held button.
        for (int k = 0; k < 12; k++) begin
            step(2'b10, 1'b0);
            check("post_rst_press", pressed, (k == 9) ? 2'b01 : 2'b00);
            check("post_rst_no_release", released, 2'b00);
        end

        // Simultaneous channels.
        for (int k = 0; k < 12; k++) step(2'b11, 1'b0);
        cnt = 0;
        cnt_bad = 0;
        for (int k = 0; k < 14; k++) begin
            step(2'b00, 1'b0);
            if (pressed == 2'b11) cnt++;
            else if (pressed != 2'b00) cnt_bad++;
        end
        check_int("simul_press_once", cnt, 1);
        check_int("simul_no_split", cnt_bad, 0);

        // Randomised runs against the model.
        for (int c = 0; c < CH; c++) begin
            lv[c]   = 1'b0;
            left[c] = 0;
        end
        for (int k = 0; k < 2000; k++) begin
            logic [1:0] bn;
            for (int c = 0; c < CH; c++) begin
                if (left[c] == 0) begin
                    lv[c]   = 1'($urandom_range(0, 1));
                    left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45)
                                                          : $urandom_range(1, 12);
                end
                left[c]--;
                bn[c] = lv[c];
            end
            step(bn, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
